muldiv_unit: RTL

- Parametrised multi-cycle multiply/divide unit for the execute stage.
- Generalises the single-width combinational multiplier and fixed divider into one WIDTH-generic block.
- Provides a configurable-latency pipelined multiplier and an iterative radix-2 restoring divider.
- Uses a start/busy/done handshake and annul (flush) support, and delivers a 2*WIDTH {hi,lo} result to the HI/LO register.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Execute-stage multiply/divide bus bundle.
//   master : issuing side  -> start_i, op_i, a_i, b_i, annul_i
//   slave  : muldiv_unit   -> busy_o, done_o, result_o {hi,lo}, div_zero_o
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                   start_i;
  logic [1:0]             op_i;
  logic [WIDTH-1:0]       a_i;
  logic [WIDTH-1:0]       b_i;
  logic                   annul_i;
  logic                   busy_o;
  logic                   done_o;
  logic [2*WIDTH-1:0]     result_o;
  logic                   div_zero_o;

  modport master (
    output start_i, op_i, a_i, b_i, annul_i,
    input  busy_o, done_o, result_o, div_zero_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, annul_i,
    output busy_o, done_o, result_o, div_zero_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit producing a 2*WIDTH {hi,lo} result.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : muldiv_unit_if.slave
//     start_i/op_i/a_i/b_i : request, sampled only while idle or in DONE
//     annul_i              : flush of the in-flight operation
//     busy_o/done_o        : handshake, done_o is a one-cycle pulse
//     result_o             : product, or {remainder, quotient}
//     div_zero_o           : set with done_o for a divide by zero
// op_i: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
module muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int unsigned W2      = 2 * WIDTH;
  localparam int unsigned CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  // Retiming stages between the product and the result register (dummy when unused)
  localparam int unsigned PIPE_D  = (MUL_LATENCY > 2) ? (MUL_LATENCY - 2) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [W2-1:0]      result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_mag_q;
  logic [WIDTH-1:0]   b_mag_q;
  logic               a_neg_q;
  logic               b_neg_q;
  logic [WIDTH-1:0]   div_quo_q;
  logic [WIDTH-1:0]   div_rem_q;
  logic [W2-1:0]      mul_pipe_q [PIPE_D];
  logic [PIPE_D-1:0]  mul_vld_q;

  logic               in_sgn_c;
  logic               a_neg_in_c;
  logic               b_neg_in_c;
  logic [WIDTH-1:0]   a_mag_in_c;
  logic [WIDTH-1:0]   b_mag_in_c;
  logic [W2-1:0]      prod_in_c;
  logic [W2-1:0]      mul_res_in_c;
  logic [W2-1:0]      prod_c;
  logic [W2-1:0]      mul_src_c;
  logic [W2-1:0]      mul_res_c;
  logic               mul_last_c;
  logic [WIDTH:0]     rem_sh_c;
  logic               div_ge_c;
  logic [WIDTH-1:0]   div_rem_d;
  logic [WIDTH-1:0]   div_quo_d;
  logic [WIDTH-1:0]   quo_fix_c;
  logic [WIDTH-1:0]   rem_fix_c;
  logic               accept_c;

  // Operand magnitudes, multiplier datapath and one restoring-divide step
  always_comb begin
    in_sgn_c     = ~bus.op_i[0];
    a_neg_in_c   = in_sgn_c & bus.a_i[WIDTH-1];
    b_neg_in_c   = in_sgn_c & bus.b_i[WIDTH-1];
    a_mag_in_c   = a_neg_in_c ? (WIDTH'(0) - bus.a_i) : bus.a_i;
    b_mag_in_c   = b_neg_in_c ? (WIDTH'(0) - bus.b_i) : bus.b_i;

    // Single-cycle product straight from the inputs (MUL_LATENCY == 1 only)
    prod_in_c    = W2'(a_mag_in_c) * W2'(b_mag_in_c);
    mul_res_in_c = (a_neg_in_c ^ b_neg_in_c) ? (W2'(0) - prod_in_c) : prod_in_c;

    prod_c       = W2'(a_mag_q) * W2'(b_mag_q);
    mul_src_c    = (MUL_LATENCY > 2) ? mul_pipe_q[PIPE_D-1] : prod_c;
    mul_res_c    = (a_neg_q ^ b_neg_q) ? (W2'(0) - mul_src_c) : mul_src_c;
    mul_last_c   = (MUL_LATENCY > 2) ? mul_vld_q[PIPE_D-1] : 1'b1;

    // Partial remainder shifted left with the next dividend bit (WIDTH+1 bits)
    rem_sh_c     = {div_rem_q, div_quo_q[WIDTH-1]};
    div_ge_c     = (rem_sh_c >= {1'b0, b_mag_q});
    // Difference is below the divisor, so WIDTH bits suffice
    div_rem_d    = div_ge_c ? (rem_sh_c[WIDTH-1:0] - b_mag_q) : rem_sh_c[WIDTH-1:0];
    div_quo_d    = {div_quo_q[WIDTH-2:0], div_ge_c};

    // Truncating division: remainder follows the dividend sign
    quo_fix_c    = (a_neg_q ^ b_neg_q) ? (WIDTH'(0) - div_quo_q) : div_quo_q;
    rem_fix_c    = a_neg_q ? (WIDTH'(0) - div_rem_q) : div_rem_q;

    accept_c     = bus.start_i & ~bus.annul_i;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      result_q   <= '0;
      cnt_q      <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_quo_q  <= '0;
      div_rem_q  <= '0;
      mul_pipe_q <= '{default: '0};
      mul_vld_q  <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        // DONE accepts a new request exactly like IDLE (back-to-back issue)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (accept_c) begin
            a_mag_q <= a_mag_in_c;
            b_mag_q <= b_mag_in_c;
            a_neg_q <= a_neg_in_c;
            b_neg_q <= b_neg_in_c;
            cnt_q   <= '0;
            if (!bus.op_i[1]) begin
              if (MUL_LATENCY == 1) begin
                state_q  <= ST_DONE;
                done_q   <= 1'b1;
                result_q <= mul_res_in_c;
              end else begin
                state_q  <= ST_MUL;
                busy_q   <= 1'b1;
              end
            end else if (bus.b_i == '0) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              dz_q     <= 1'b1;
              result_q <= {bus.a_i, {WIDTH{1'b1}}};
            end else begin
              state_q   <= ST_DIV;
              busy_q    <= 1'b1;
              div_quo_q <= a_mag_in_c;
              div_rem_q <= '0;
            end
          end
        end

        ST_MUL: begin
          if (bus.annul_i) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            mul_vld_q <= '0;
          end else begin
            mul_pipe_q[0] <= prod_c;
            for (int i = 1; i < int'(PIPE_D); i++) begin
              mul_pipe_q[i] <= mul_pipe_q[i-1];
            end
            mul_vld_q <= PIPE_D'({mul_vld_q, 1'b1});
            if (mul_last_c && (cnt_q == CNT_W'(MUL_LATENCY - 2))) begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              result_q  <= mul_res_c;
              cnt_q     <= '0;
              mul_vld_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        ST_DIV: begin
          if (bus.annul_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            div_rem_q <= div_rem_d;
            div_quo_q <= div_quo_d;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= ST_FIX;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        ST_FIX: begin
          busy_q <= 1'b0;
          if (bus.annul_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= {rem_fix_c, quo_fix_c};
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.result_o   = result_q;
  assign bus.div_zero_o = dz_q;

endmodule
